mux_hold_seq: RTL and testbench

Parametrised, registered N-channel multiplexer with a built-in select sequencer. It replaces ad-hoc combinational case muxes, whose out-of-range selects can infer latches, with an explicit, clocked hold-on-invalid policy. In auto mode the select steps through the channels on a programmable interval. In external mode the select is driven directly. It sits between stimulus/data sources and a single consumer in the synthesis-study designs.

---
 rtl/mux_hold_seq.sv | 113 +++++++++++
 tb/tb_mux_hold_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_hold_seq.sv
// mux_hold_seq: registered N-channel multiplexer with a built-in select
// sequencer. Auto mode (mode=0) steps the select through the channels every
// STEP enabled cycles. External mode (mode=1) takes sel_ext directly.
// Out-of-range selects hold y and flag sel_err.
// Optional feature macro: MUX_ERR_CNT_EN adds the saturating err_cnt output.
module mux_hold_seq #(
    parameter int WIDTH = 1,
    parameter int NCH   = 3,
    parameter int SELW  = 2,
    parameter int STEP  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel_ext,
    input  logic                  step_en,
    input  logic [NCH*WIDTH-1:0]  din,
    output logic [WIDTH-1:0]      y,
    output logic [SELW-1:0]       sel_q,
    output logic                  sel_err,
    output logic                  wrap
`ifdef MUX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int PRE_W = (STEP > 1) ? $clog2(STEP) : 1;

    // NCH needs one bit more than a select when 2**SELW == NCH.
    localparam logic [SELW:0]    NCH_EXT  = (SELW+1)'(NCH);
    localparam logic [SELW-1:0]  LAST_CH  = SELW'(NCH - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP - 1);

    logic [PRE_W-1:0] pre;
    logic [SELW-1:0]  cnt;
    logic [SELW-1:0]  s;
    logic             s_valid;
    logic [WIDTH-1:0] pick;

    // Effective select: mode switches combinationally ahead of the registers.
    assign s       = mode ? sel_ext : cnt;
    assign s_valid = {1'b0, s} < NCH_EXT;

    // Channel selection; only channels that exist are compared against s.
    always_comb begin
        // NOTE: default first so no path through this block leaves pick
        // unassigned; an incomplete case here is exactly what infers a latch.
        pick = '0;
        for (int k = 0; k < NCH; k++) begin
            if (s == SELW'(k)) begin
                pick = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register stage: y holds on invalid select, sel_q/sel_err track s.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge
        // values regardless of statement order.
        if (!reset_n) begin
            y       <= '0;
            sel_q   <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_q <= s;
            // NOTE: the hold is a clock enable on y (no else branch for y),
            // which stays a flop; it is not a combinational latch.
            if (s_valid) begin
                y       <= pick;
                sel_err <= 1'b0;
            end else begin
                sel_err <= 1'b1;
            end
        end
    end

    // Auto-mode sequencer: prescaler, channel counter and wrap pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!mode && step_en) begin
                if (pre == PRE_LAST) begin
                    pre <= '0;
                    if (cnt == LAST_CH) begin
                        cnt  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

`ifdef MUX_ERR_CNT_EN
    // Saturating count of edges that saw an out-of-range select.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (!s_valid && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_hold_seq.sv
// Self-checking bench for mux_hold_seq (NCH=3, WIDTH=1, SELW=2, STEP=4).
// Directed table, hand-written corner sequences, then random stimulus
// against a tick-count reference model.
module tb_mux_hold_seq;

    localparam int WIDTH = 1;
    localparam int NCH   = 3;
    localparam int SELW  = 2;
    localparam int STEP  = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 mode;
    logic [SELW-1:0]      sel_ext;
    logic                 step_en;
    logic [NCH*WIDTH-1:0] din;
    logic [WIDTH-1:0]     y;
    logic [SELW-1:0]      sel_q;
    logic                 sel_err;
    logic                 wrap;
`ifdef MUX_ERR_CNT_EN
    logic [7:0]           err_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: total enabled auto steps modulo a full sequence.
    int               m_ticks;
    logic [WIDTH-1:0] m_y;
    int               m_selq;
    int               m_err;
    int               m_wrap;
    int               m_ecnt;

    typedef struct {
        logic                 rn;
        logic                 md;
        logic [SELW-1:0]      se;
        logic                 st;
        logic [NCH*WIDTH-1:0] d;
        logic [WIDTH-1:0]     ey;
        logic [SELW-1:0]      esq;
        logic                 eerr;
        logic                 ewrap;
    } vec_t;

    vec_t tbl[14];

    mux_hold_seq #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW),
        .STEP  (STEP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode),
        .sel_ext (sel_ext),
        .step_en (step_en),
        .din     (din),
        .y       (y),
        .sel_q   (sel_q),
        .sel_err (sel_err),
        .wrap    (wrap)
`ifdef MUX_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: cnt and pre are derived from the tick count by plain arithmetic.
    task automatic model_edge(input logic rn, input logic md, input logic [SELW-1:0] se,
                              input logic st, input logic [NCH*WIDTH-1:0] d);
        int s;
        if (!rn) begin
            m_ticks = 0; m_y = '0; m_selq = 0; m_err = 0; m_wrap = 0; m_ecnt = 0;
        end else begin
            s = md ? int'(se) : (m_ticks / STEP) % NCH;
            m_selq = s;
            if (s < NCH) begin
                m_y   = d[s*WIDTH +: WIDTH];
                m_err = 0;
            end else begin
                m_err = 1;
                if (m_ecnt < 255) m_ecnt++;
            end
            m_wrap = 0;
            if (!md && st) begin
                m_ticks = (m_ticks + 1) % (NCH * STEP);
                m_wrap  = (m_ticks == 0) ? 1 : 0;
            end
        end
    endtask

    // Apply one cycle of inputs, step the model, sample 1 ns after the edge.
    task automatic drive(input logic rn, input logic md, input logic [SELW-1:0] se,
                         input logic st, input logic [NCH*WIDTH-1:0] d);
        reset_n = rn; mode = md; sel_ext = se; step_en = st; din = d;
        model_edge(rn, md, se, st, d);
        @(posedge clk);
        #1;
    endtask

    task automatic auto_edges(input int n, input logic [NCH*WIDTH-1:0] d);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b1, d);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".y"},       32'(y),       32'(m_y));
        check({tag, ".sel_q"},   32'(sel_q),   32'(m_selq));
        check({tag, ".sel_err"}, 32'(sel_err), 32'(m_err));
        check({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
`ifdef MUX_ERR_CNT_EN
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_ecnt));
`endif
    endtask

    initial begin
        // Auto sequence from reset: sel_q 0x4, 1x4, 2x4, wrap on edge 12.
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 1'b1, 3'b101, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd2, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'b101, 1'b1, 2'd0, 1'b0, 1'b0};

        reset_n = 1'b0; mode = 1'b0; sel_ext = '0; step_en = 1'b0; din = '0;
        drive(1'b0, 1'b0, '0, 1'b0, 3'b000);
        drive(1'b0, 1'b0, '0, 1'b0, 3'b000);
        check("reset.y", 32'(y), 0);
        check("reset.sel_q", 32'(sel_q), 0);
        check("reset.sel_err", 32'(sel_err), 0);
        check("reset.wrap", 32'(wrap), 0);

        // Directed auto-sequencing table.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rn, tbl[i].md, tbl[i].se, tbl[i].st, tbl[i].d);
            check($sformatf("tbl%0d.y", i),       32'(y),       32'(tbl[i].ey));
            check($sformatf("tbl%0d.sel_q", i),   32'(sel_q),   32'(tbl[i].esq));
            check($sformatf("tbl%0d.sel_err", i), 32'(sel_err), 32'(tbl[i].eerr));
            check($sformatf("tbl%0d.wrap", i),    32'(wrap),    32'(tbl[i].ewrap));
        end

        // Reset mid-run with cnt=2, y=1; reset wins for both low edges.
        drive(1'b0, 1'b0, '0, 1'b1, 3'b101);
        auto_edges(9, 3'b101);
        check("midrst.pre.sel_q", 32'(sel_q), 2);
        check("midrst.pre.y", 32'(y), 1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 2'd3, 1'b1, 3'b111);
            check("midrst.y", 32'(y), 0);
            check("midrst.sel_q", 32'(sel_q), 0);
            check("midrst.sel_err", 32'(sel_err), 0);
            check("midrst.wrap", 32'(wrap), 0);
        end
        auto_edges(4, 3'b101);
        check("midrst.post4.sel_q", 32'(sel_q), 0);
        auto_edges(1, 3'b101);
        check("midrst.post5.sel_q", 32'(sel_q), 1);

        // Prescaler gating at pre=2.
        drive(1'b0, 1'b0, '0, 1'b0, 3'b000);
        auto_edges(2, 3'b010);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0, 3'b010);
            check("gate.frozen.sel_q", 32'(sel_q), 0);
        end
        auto_edges(1, 3'b010);
        check("gate.en1.sel_q", 32'(sel_q), 0);
        auto_edges(1, 3'b010);
        check("gate.en2.sel_q", 32'(sel_q), 0);
        auto_edges(1, 3'b010);
        check("gate.en3.sel_q", 32'(sel_q), 1);
        check("gate.en3.y", 32'(y), 1);

        // Mode switching at cnt=1, pre=3 (terminal count while mode=1).
        drive(1'b0, 1'b0, '0, 1'b0, 3'b000);
        auto_edges(7, 3'b100);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b1, 3'b100);
            check("mode.ext.sel_q", 32'(sel_q), 0);
            check("mode.ext.wrap", 32'(wrap), 0);
        end
        auto_edges(1, 3'b100);
        check("mode.back1.sel_q", 32'(sel_q), 1);
        auto_edges(1, 3'b100);
        check("mode.back2.sel_q", 32'(sel_q), 2);
        check("mode.back2.y", 32'(y), 1);

        // Invalid external select holds y.
        drive(1'b0, 1'b0, '0, 1'b0, 3'b000);
        drive(1'b1, 1'b1, 2'd1, 1'b0, 3'b010);
        check("inv.sel1.y", 32'(y), 1);
        check("inv.sel1.sel_err", 32'(sel_err), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'd3, 1'b0, (i % 2 == 0) ? 3'b000 : 3'b111);
            check("inv.hold.y", 32'(y), 1);
            check("inv.hold.sel_q", 32'(sel_q), 3);
            check("inv.hold.sel_err", 32'(sel_err), 1);
        end
`ifdef MUX_ERR_CNT_EN
        check("inv.err_cnt", 32'(err_cnt), 3);
`endif
        drive(1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
        check("inv.clear.sel_err", 32'(sel_err), 0);
        check("inv.clear.y", 32'(y), 0);

`ifdef MUX_ERR_CNT_EN
        // Saturation at 255, then reset clears it.
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 2'd3, 1'b0, 3'b101);
        check("sat.err_cnt", 32'(err_cnt), 255);
        drive(1'b1, 1'b1, 2'd3, 1'b0, 3'b101);
        check("sat.hold.err_cnt", 32'(err_cnt), 255);
        drive(1'b0, 1'b1, 2'd3, 1'b0, 3'b101);
        check("sat.reset.err_cnt", 32'(err_cnt), 0);
`endif

        // Random stimulus against the reference model.
        drive(1'b0, 1'b0, '0, 1'b0, 3'b000);
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) == 0),
                  SELW'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) != 0),
                  3'($urandom_range(0, 7)));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
